// File: rtl/ddr_rsm_pkg.sv
// rtl/ddr_rsm_pkg.sv - shared defaults, state type and constants for the DDR read stream master
// No ports: holds the default widths, the master FSM state type and the
// all-bytes-enabled byteenable value used on every read.
package ddr_rsm_pkg;

  localparam int DEF_ADDR_W = 24;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LEN_W  = 16;

  localparam logic [3:0] AVM_BE_ALL = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } rsm_state_e;

endpackage

// File: rtl/ddr_rsm_resp_fifo.sv
// rtl/ddr_rsm_resp_fifo.sv - show-ahead response FIFO for the DDR read stream master
// Ports:
//   slave_clk, slave_reset_n : clock, asynchronous active-low reset
//   push, push_data          : write one word
//   pop                      : drop the head word (ignored when empty)
//   pop_data                 : head word, valid whenever !empty
//   empty, used              : occupancy, both taken straight from the count register
module ddr_rsm_resp_fifo
  import ddr_rsm_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                             slave_clk,
  input  logic                             slave_reset_n,
  input  logic                             push,
  input  logic [DATA_W-1:0]                push_data,
  input  logic                             pop,
  output logic [DATA_W-1:0]                pop_data,
  output logic                             empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  used
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int UW = $clog2(FIFO_DEPTH+1);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop & (used != '0);
  // A full FIFO can still take a push in the cycle it is popped.
  assign do_push = push & ((used != UW'(FIFO_DEPTH)) | do_pop);

  always_ff @(posedge slave_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge slave_clk or negedge slave_reset_n) begin
    if (!slave_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      used <= used + UW'(1);
      else if (!do_push && do_pop) used <= used - UW'(1);
    end
  end

  assign pop_data = mem[rd_ptr];
  assign empty    = (used == '0);

endmodule

// File: rtl/ddr_read_stream_master.sv
// rtl/ddr_read_stream_master.sv - Avalon-MM pipelined read master feeding a valid/ready stream
// Ports:
//   slave_clk, slave_reset_n              : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_addr/cmd_len  : command handshake (start word address, word count)
//   busy, done, error                     : status (done is a one-cycle pulse, error is sticky)
//   avm_*                                 : read master towards the clock-crossing bridge slave
//   out_valid/out_data/out_ready          : returned data stream, in issue order
module ddr_read_stream_master
  import ddr_rsm_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int LEN_W       = DEF_LEN_W,
  parameter int MAX_PENDING = 8,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic              slave_clk,
  input  logic              slave_reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_endofpacket,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  localparam int PW = $clog2(MAX_PENDING+1);
  localparam int UW = $clog2(FIFO_DEPTH+1);
  localparam int SW = UW + 1;

  rsm_state_e       state;
  rsm_state_e       state_nxt;
  logic [LEN_W-1:0] remaining;
  logic [LEN_W-1:0] remaining_nxt;
  logic [PW-1:0]    pending;
  logic [PW-1:0]    pending_nxt;
  logic [UW-1:0]    fifo_used;
  logic [UW-1:0]    used_nxt;
  logic             fifo_empty;
  logic             cmd_fire;
  logic             rd_fire;
  logic             rsp_push;
  logic             rsp_stale;
  logic             pop;
  logic             credit_nxt;
  logic             avm_read_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic             cmd_ready_nxt;
  logic             unused_eop;

  assign unused_eop     = avm_endofpacket;
  assign avm_byteenable = AVM_BE_ALL;

  assign cmd_fire  = cmd_valid & cmd_ready;
  assign rd_fire   = avm_read & ~avm_waitrequest;
  // Data with nothing outstanding belongs to a read from before a reset.
  assign rsp_push  = avm_readdatavalid & (pending != '0);
  assign rsp_stale = avm_readdatavalid & (pending == '0);
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;

  ddr_rsm_resp_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_resp_fifo (
    .slave_clk     (slave_clk),
    .slave_reset_n (slave_reset_n),
    .push          (rsp_push),
    .push_data     (avm_readdata),
    .pop           (pop),
    .pop_data      (out_data),
    .empty         (fifo_empty),
    .used          (fifo_used)
  );

  // Next-cycle counters; the registered outputs are computed from these so
  // that avm_read already reflects the credit after this edge.
  always_comb begin
    pending_nxt = pending;
    if (rd_fire && !rsp_push)      pending_nxt = pending + PW'(1);
    else if (!rd_fire && rsp_push) pending_nxt = pending - PW'(1);

    used_nxt = fifo_used;
    if (rsp_push && !pop)      used_nxt = fifo_used + UW'(1);
    else if (!rsp_push && pop) used_nxt = fifo_used - UW'(1);

    remaining_nxt = remaining;
    if (cmd_fire)     remaining_nxt = cmd_len;
    else if (rd_fire) remaining_nxt = remaining - LEN_W'(1);
  end

  always_ff @(posedge slave_clk or negedge slave_reset_n) begin
    if (!slave_reset_n) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_fire) state_nxt = (cmd_len == '0) ? DONE : ISSUE;
      ISSUE:   if (rd_fire && remaining == LEN_W'(1)) state_nxt = DRAIN;
      DRAIN:   if (pending == '0 && fifo_used == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Issue and pop are the only things that move pending + used, so credit
  // cannot vanish mid-stall; the explicit hold keeps the request stable anyway.
  always_comb begin
    credit_nxt    = (pending_nxt < PW'(MAX_PENDING)) &&
                    ((SW'(pending_nxt) + SW'(used_nxt)) < SW'(FIFO_DEPTH));
    avm_read_nxt  = (avm_read & avm_waitrequest) |
                    ((state_nxt == ISSUE) && (remaining_nxt != '0) && credit_nxt);
    busy_nxt      = (state_nxt == ISSUE) || (state_nxt == DRAIN);
    done_nxt      = (state_nxt == DONE);
    cmd_ready_nxt = (state_nxt == IDLE);
  end

  always_ff @(posedge slave_clk or negedge slave_reset_n) begin
    if (!slave_reset_n) begin
      remaining   <= '0;
      pending     <= '0;
      avm_address <= '0;
      avm_read    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cmd_ready   <= 1'b0;
      error       <= 1'b0;
    end else begin
      remaining <= remaining_nxt;
      pending   <= pending_nxt;
      avm_read  <= avm_read_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      cmd_ready <= cmd_ready_nxt;
      if (cmd_fire)     avm_address <= cmd_addr;
      else if (rd_fire) avm_address <= avm_address + ADDR_W'(1);
      // A stale response in the accept cycle still counts as an error.
      error <= (error & ~cmd_fire) | rsp_stale;
    end
  end

endmodule
